// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants and state type for the 7-segment scan controller.
package seg_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GUARD,
    S_SHOW
  } state_e;
endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Digit write channel: valid/ready handshake carrying target digit and BCD value.
interface seg_scan_ctrl_if #(
  parameter int unsigned DIGITS = 8
) ();
  localparam int unsigned IW = $clog2(DIGITS);

  logic          wr_valid;
  logic          wr_ready;
  logic [IW-1:0] wr_idx;
  logic [3:0]    wr_bcd;

  modport master (output wr_valid, wr_idx, wr_bcd, input wr_ready);
  modport slave  (input wr_valid, wr_idx, wr_bcd, output wr_ready);
endinterface

// File: rtl/bcd7seg.sv
// BCD to active-low 7-segment decoder, seg[6]=a .. seg[0]=g; 10..15 blank.
module bcd7seg (
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);
  always_comb begin
    seg_o = 7'h7F;
    case (bcd_i)
      4'd0: seg_o = 7'b0000001;
      4'd1: seg_o = 7'b1001111;
      4'd2: seg_o = 7'b0010010;
      4'd3: seg_o = 7'b0000110;
      4'd4: seg_o = 7'b1001100;
      4'd5: seg_o = 7'b0100100;
      4'd6: seg_o = 7'b0100000;
      4'd7: seg_o = 7'b0001111;
      4'd8: seg_o = 7'b0000000;
      4'd9: seg_o = 7'b0000100;
      default: seg_o = 7'h7F;
    endcase
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with shadow/active digit registers
// committed at frame boundaries and a single shared decoder.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS = 8,
  parameter int unsigned DWELL  = 50000,
  parameter int unsigned GUARD  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  seg_scan_ctrl_if.slave    wr,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              frame_done
);
  localparam int unsigned IW   = $clog2(DIGITS);
  localparam int unsigned CMAX = (DWELL > GUARD) ? DWELL : GUARD;
  localparam int unsigned CW   = $clog2(CMAX + 1);
  localparam logic [IW-1:0] LAST     = IW'(DIGITS - 1);
  localparam logic [CW-1:0] DWELL_LD = CW'(DWELL - 1);
  localparam logic [CW-1:0] GUARD_LD = CW'((GUARD == 0) ? 0 : GUARD - 1);

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [3:0]        shadow_q [DIGITS];
  logic [3:0]        shadow_d [DIGITS];
  logic [3:0]        active_q [DIGITS];
  logic [3:0]        active_d [DIGITS];
  logic [6:0]        seg_q, seg_d, seg_dec;
  logic [DIGITS-1:0] an_q, an_d;
  logic              ready_q, ready_d;
  logic              fd_q, fd_d;
  logic              last_d;
  logic [3:0]        bcd_sel;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;

    if (wr.wr_valid && ready_q && ({1'b0, wr.wr_idx} < (IW + 1)'(DIGITS)))
      shadow_d[wr.wr_idx] = wr.wr_bcd;

    if (!en) begin
      state_d = S_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          idx_d = '0;
          if (GUARD == 0) begin
            state_d = S_SHOW;
            cnt_d   = DWELL_LD;
          end else begin
            state_d = S_GUARD;
            cnt_d   = GUARD_LD;
          end
        end
        S_GUARD: begin
          if (cnt_q == '0) begin
            state_d = S_SHOW;
            cnt_d   = DWELL_LD;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        S_SHOW: begin
          if (cnt_q == '0) begin
            // Commit uses shadow_q: writes are refused in this cycle, so nothing is lost.
            if (idx_q == LAST) begin
              idx_d    = '0;
              active_d = shadow_q;
            end else begin
              idx_d = idx_q + IW'(1);
            end
            if (GUARD == 0) begin
              state_d = S_SHOW;
              cnt_d   = DWELL_LD;
            end else begin
              state_d = S_GUARD;
              cnt_d   = GUARD_LD;
            end
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are precomputed from next-state so they change on the state-entry edge.
  always_comb begin
    bcd_sel = active_d[idx_d];
    last_d  = (state_d == S_SHOW) && (idx_d == LAST) && (cnt_d == '0);
    seg_d   = SEG_BLANK;
    an_d    = '1;
    if (state_d == S_SHOW) begin
      seg_d        = seg_dec;
      an_d[idx_d]  = 1'b0;
    end
    ready_d = !last_d;
    fd_d    = last_d;
  end

  bcd7seg u_dec (
    .bcd_i (bcd_sel),
    .seg_o (seg_dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '{default: BCD_BLANK};
      active_q <= '{default: BCD_BLANK};
      seg_q    <= SEG_BLANK;
      an_q     <= '1;
      ready_q  <= 1'b1;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      ready_q  <= ready_d;
      fd_q     <= fd_d;
    end
  end

  assign wr.wr_ready = ready_q;
  assign seg         = seg_q;
  assign an          = an_q;
  assign frame_done  = fd_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench: two builds (GUARD=2 and GUARD=0) share stimulus; a frame-position
// reference model queues expected outputs, a negedge monitor pops and compares.
module tb_seg_scan_ctrl;
  localparam int D  = 4;
  localparam int DW = 4;

  typedef struct {
    logic [6:0] seg;
    logic [3:0] an;
    logic       rdy;
    logic       fd;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       wv  = 1'b0;
  logic [1:0] wi  = '0;
  logic [3:0] wb  = '0;

  logic [6:0] seg_a, seg_b;
  logic [3:0] an_a, an_b;
  logic       fd_a, fd_b;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl_if #(.DIGITS(D)) if_a ();
  seg_scan_ctrl_if #(.DIGITS(D)) if_b ();

  assign if_a.wr_valid = wv;
  assign if_a.wr_idx   = wi;
  assign if_a.wr_bcd   = wb;
  assign if_b.wr_valid = wv;
  assign if_b.wr_idx   = wi;
  assign if_b.wr_bcd   = wb;

  seg_scan_ctrl #(.DIGITS(D), .DWELL(DW), .GUARD(2)) dut_a (
    .clk(clk), .rst(rst), .en(en), .wr(if_a),
    .seg(seg_a), .an(an_a), .frame_done(fd_a)
  );

  seg_scan_ctrl #(.DIGITS(D), .DWELL(DW), .GUARD(0)) dut_b (
    .clk(clk), .rst(rst), .en(en), .wr(if_b),
    .seg(seg_b), .an(an_b), .frame_done(fd_b)
  );

  // Reference segment patterns written as the set of lit segments per digit.
  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    string      lit;
    logic [6:0] s;
    int         k;
    s = 7'h7F;
    case (v)
      4'd0: lit = "abcdef";
      4'd1: lit = "bc";
      4'd2: lit = "abdeg";
      4'd3: lit = "abcdg";
      4'd4: lit = "bcfg";
      4'd5: lit = "acdfg";
      4'd6: lit = "acdefg";
      4'd7: lit = "abc";
      4'd8: lit = "abcdefg";
      4'd9: lit = "abcdfg";
      default: lit = "";
    endcase
    for (int i = 0; i < lit.len(); i++) begin
      k = int'(lit[i]) - 97;
      s[6 - k] = 1'b0;
    end
    return s;
  endfunction

  int         gk  [2] = '{2, 0};
  bit         run [2];
  int         pos [2];
  bit         rdy [2];
  logic [3:0] sh  [2][D];
  logic [3:0] act [2][D];
  exp_t       qa[$];
  exp_t       qb[$];

  function automatic exp_t reset_exp();
    exp_t e;
    e.seg = 7'h7F;
    e.an  = 4'hF;
    e.rdy = 1'b1;
    e.fd  = 1'b0;
    return e;
  endfunction

  task automatic model_step(input int k, output exp_t e);
    int frame, slot, w;
    frame = D * (DW + gk[k]);
    if (rst) begin
      run[k] = 0;
      pos[k] = 0;
      rdy[k] = 1;
      for (int i = 0; i < D; i++) begin
        sh[k][i]  = 4'hF;
        act[k][i] = 4'hF;
      end
    end else begin
      if (wv && rdy[k]) sh[k][wi] = wb;
      if (!en) run[k] = 0;
      else if (!run[k]) begin
        run[k] = 1;
        pos[k] = 0;
      end else if (pos[k] == frame - 1) begin
        for (int i = 0; i < D; i++) act[k][i] = sh[k][i];
        pos[k] = 0;
      end else pos[k] = pos[k] + 1;
    end
    e = reset_exp();
    rdy[k] = !(run[k] && pos[k] == frame - 1);
    e.rdy  = rdy[k];
    e.fd   = !rdy[k];
    if (run[k]) begin
      slot = pos[k] / (DW + gk[k]);
      w    = pos[k] % (DW + gk[k]);
      if (w >= gk[k]) begin
        e.an  = 4'hF & ~(4'b0001 << slot);
        e.seg = ref_seg(act[k][slot]);
      end
    end
  endtask

  always @(posedge clk) begin
    exp_t ea, eb;
    model_step(0, ea);
    model_step(1, eb);
    qa.push_back(ea);
    qb.push_back(eb);
  end

  task automatic check(input string name, input exp_t got, input exp_t exp);
    n_chk++;
    if (got.seg === exp.seg && got.an === exp.an && got.rdy === exp.rdy && got.fd === exp.fd)
      n_pass++;
    else
      $display("FAIL %s t=%0t: got seg=%b an=%h rdy=%b fd=%b, want seg=%b an=%h rdy=%b fd=%b",
               name, $time, got.seg, got.an, got.rdy, got.fd, exp.seg, exp.an, exp.rdy, exp.fd);
  endtask

  function automatic exp_t got_a();
    exp_t g;
    g.seg = seg_a; g.an = an_a; g.rdy = if_a.wr_ready; g.fd = fd_a;
    return g;
  endfunction

  function automatic exp_t got_b();
    exp_t g;
    g.seg = seg_b; g.an = an_b; g.rdy = if_b.wr_ready; g.fd = fd_b;
    return g;
  endfunction

  always @(negedge clk) begin
    if (qa.size() > 0) check("scan_g2", got_a(), qa.pop_front());
    if (qb.size() > 0) check("scan_g0", got_b(), qb.pop_front());
  end

  task automatic step(input logic v, input int i, input int b);
    @(posedge clk);
    #1;
    wv = v;
    wi = 2'(i);
    wb = 4'(b);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) step(1'b0, 0, 0);

    for (int i = 0; i < D; i++) step(1'b1, i, i + 1);
    step(1'b0, 0, 0);
    en = 1'b1;
    repeat (60) step(1'b0, 0, 0);

    repeat (60) step(1'b1, $urandom_range(0, 3), $urandom_range(0, 15));

    step(1'b1, 2, 7);
    step(1'b1, 2, 9);
    step(1'b1, 0, 12);
    repeat (60) step(1'b0, 0, 0);

    for (int c = 0; c < 400; c++) begin
      step(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) en = ~en;
    end

    en = 1'b1;
    repeat (37) step(1'b0, 0, 0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("async_rst_g2", got_a(), reset_exp());
    check("async_rst_g0", got_b(), reset_exp());
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (60) step(1'b0, 0, 0);

    for (int c = 0; c < 200; c++)
      step(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 15));

    @(negedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
